// File: rtl/sar_adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_scan_ctrl
// Multi-channel SAR ADC sequencer. It steps through the enabled analog mux
// channels. For each channel it samples, runs a binary-search conversion
// (MSB first) and optionally averages 2^a conversions. The result is presented
// on a valid/ready port, tagged with the channel index.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             start a sweep (only honoured in IDLE with a non-zero mask)
//   cont_i              at sweep end: 1 wraps to the lowest channel, 0 returns to IDLE
//   ch_mask_i           enabled channels, latched at start
//   avg_log2_i          averaging exponent, latched at start, clamped to MAX_AVG_LOG2
//   sample_cycles_i     sample length in cycles, latched at start (0 acts as 1)
//   comp_p_i, comp_n_i  differential comparator outputs
//   sample_o            track/sample switch enable
//   ch_sel_o            analog mux select
//   dac_p_o, dac_n_o    trial code to the capacitor DACs (dac_n_o = ~dac_p_o)
//   busy_o              sequencer not idle
//   res_valid_o/res_ready_i/res_data_o/res_ch_o  result port
//   comp_err_o          sticky: comparator outputs were equal at a decision
//
// Result handshake: res_data_o/res_ch_o are held stable while res_valid_o=1.
// A transfer happens on any rising edge where res_valid_o && res_ready_i. The
// holding register may be reloaded on that same edge, so one result per cycle
// is possible. A result is never overwritten before it has been transferred:
// the sequencer parks in HOLD until the register frees.
// -----------------------------------------------------------------------------
module sar_adc_scan_ctrl #(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 0,
    parameter int MAX_AVG_LOG2  = 4,
    parameter int SAMPLE_W      = 4,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic [NUM_CH-1:0]     ch_mask_i,
    input  logic [2:0]            avg_log2_i,
    input  logic [SAMPLE_W-1:0]   sample_cycles_i,
    input  logic                  comp_p_i,
    input  logic                  comp_n_i,
    output logic                  sample_o,
    output logic [CH_W-1:0]       ch_sel_o,
    output logic [RESOLUTION-1:0] dac_p_o,
    output logic [RESOLUTION-1:0] dac_n_o,
    output logic                  busy_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [RESOLUTION-1:0] res_data_o,
    output logic [CH_W-1:0]       res_ch_o,
    output logic                  comp_err_o
);

    localparam int ACC_W = RESOLUTION + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [RESOLUTION-1:0] MSB_ONEHOT = {1'b1, {(RESOLUTION-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [NUM_CH-1:0]     r_mask;
    logic [2:0]            r_avg;
    logic [SAMPLE_W-1:0]   r_samp;
    logic [CH_W-1:0]       r_ch;
    logic [SAMPLE_W-1:0]   r_scnt;
    logic [SET_W-1:0]      r_settle;
    logic [RESOLUTION-1:0] r_trial;
    logic [RESOLUTION-1:0] r_dac;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_conv_cnt;
    logic                  r_valid;
    logic [RESOLUTION-1:0] r_data;
    logic [CH_W-1:0]       r_res_ch;
    logic                  r_err;

    logic                  w_start;
    logic                  w_samp_end;
    logic                  w_bit_end;
    logic                  w_lsb;
    logic                  w_keep;
    logic [RESOLUTION-1:0] w_kept;
    logic                  w_conv_last;
    logic                  w_load;
    logic                  w_next_found;
    logic [CH_W-1:0]       w_next_ch;
    logic [2:0]            w_avg_clamped;
    logic [RESOLUTION-1:0] w_avg_code;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
        f_lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = CH_W'(i);
        end
    endfunction

    assign w_start       = start_i && (ch_mask_i != '0);
    assign w_samp_end    = (r_scnt == (r_samp - SAMPLE_W'(1)));
    assign w_bit_end     = (r_settle == SET_W'(SETTLE_CYCLES));
    assign w_lsb         = r_trial[0];
    // Equal comparator outputs are an invalid decision and count as "drop the bit".
    assign w_keep        = comp_p_i & ~comp_n_i;
    assign w_kept        = w_keep ? r_dac : (r_dac & ~r_trial);
    assign w_conv_last   = (r_conv_cnt == ((CNT_W'(1) << r_avg) - CNT_W'(1)));
    assign w_load        = ((r_state == S_DONE) || (r_state == S_HOLD)) &&
                           (!r_valid || res_ready_i);
    assign w_avg_clamped = (avg_log2_i > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : avg_log2_i;
    // Truncating divide by 2^a. r_avg never exceeds MAX_AVG_LOG2, so the
    // selected slice always lies inside the accumulator.
    assign w_avg_code    = r_acc[r_avg +: RESOLUTION];

    // Next enabled channel strictly above the current one.
    always_comb begin
        w_next_found = 1'b0;
        w_next_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_next_found = 1'b1;
                w_next_ch    = CH_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_next_state = S_SAMPLE;
            S_SAMPLE:  if (w_samp_end) w_next_state = S_CONVERT;
            S_CONVERT: if (w_bit_end && w_lsb) w_next_state = w_conv_last ? S_DONE : S_SAMPLE;
            S_DONE, S_HOLD: begin
                if (w_load) w_next_state = (w_next_found || cont_i) ? S_SAMPLE : S_IDLE;
                else        w_next_state = S_HOLD;
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        sample_o = (r_state == S_SAMPLE);
        busy_o   = (r_state != S_IDLE);
    end

    // Sequencing datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask     <= '0;
            r_avg      <= '0;
            r_samp     <= SAMPLE_W'(1);
            r_ch       <= '0;
            r_scnt     <= '0;
            r_settle   <= '0;
            r_trial    <= '0;
            r_dac      <= '0;
            r_acc      <= '0;
            r_conv_cnt <= '0;
            r_data     <= '0;
            r_res_ch   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mask     <= ch_mask_i;
                        r_avg      <= w_avg_clamped;
                        r_samp     <= (sample_cycles_i == '0) ? SAMPLE_W'(1) : sample_cycles_i;
                        r_ch       <= f_lowest(ch_mask_i);
                        r_acc      <= '0;
                        r_conv_cnt <= '0;
                        r_scnt     <= '0;
                        r_dac      <= '0;
                        r_trial    <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (w_samp_end) begin
                        // Present the MSB trial on the first CONVERT cycle.
                        r_scnt   <= '0;
                        r_settle <= '0;
                        r_trial  <= MSB_ONEHOT;
                        r_dac    <= MSB_ONEHOT;
                    end else begin
                        r_scnt <= r_scnt + SAMPLE_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (!w_bit_end) begin
                        r_settle <= r_settle + SET_W'(1);
                    end else begin
                        r_settle <= '0;
                        if (!w_lsb) begin
                            r_trial <= r_trial >> 1;
                            r_dac   <= w_kept | (r_trial >> 1);
                        end else begin
                            r_trial    <= '0;
                            r_dac      <= '0;
                            r_acc      <= r_acc + ACC_W'(w_kept);
                            r_conv_cnt <= w_conv_last ? '0 : (r_conv_cnt + CNT_W'(1));
                        end
                    end
                end
                S_DONE, S_HOLD: begin
                    if (w_load) begin
                        r_data   <= w_avg_code;
                        r_res_ch <= r_ch;
                        r_acc    <= '0;
                        r_ch     <= w_next_found ? w_next_ch : f_lowest(r_mask);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result valid flag and sticky comparator error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_load)           r_valid <= 1'b1;
            else if (res_ready_i) r_valid <= 1'b0;
            if ((r_state == S_CONVERT) && w_bit_end && (comp_p_i == comp_n_i)) r_err <= 1'b1;
        end
    end

    assign ch_sel_o    = r_ch;
    assign dac_p_o     = r_dac;
    assign dac_n_o     = ~r_dac;
    assign res_valid_o = r_valid;
    assign res_data_o  = r_data;
    assign res_ch_o    = r_res_ch;
    assign comp_err_o  = r_err;

endmodule
